vec_mem_responder: RTL and testbench

VEC_MEM_RESPONDER -- requirements
Module: vec_mem_responder

---
 rtl/vec_mem_responder.sv | 206 ++++++++++++++++++++
 tb/tb_vec_mem_responder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_responder.sv
// ----------------------------------------------------------------------------
// vec_mem_responder
//
// Word-addressed memory slave with pipelined read returns and a built-in
// throttle that periodically forces waitrequest. It is intended as a
// well-behaved target for exercising bus masters: it stalls on a regular
// cadence, limits outstanding reads, and returns read data in acceptance
// order after a fixed latency.
//
// Parameters
//   DEPTH_LOG2   : log2 of the number of 32-bit words stored
//   READ_LATENCY : cycles from read acceptance to readdatavalid (1..8)
//   MAX_PENDING  : maximum accepted-but-unreturned reads (1..8)
//   STALL_EVERY  : one forced waitrequest cycle after this many accepted
//                  transfers (0 disables the throttle)
//
// Ports
//   clk                 : clock, all state updates on the rising edge
//   rst                 : synchronous active-high reset
//   slave_address       : byte address, bits [1:0] ignored, upper bits wrap
//   slave_read          : read request
//   slave_write         : write request (wins when both are high)
//   slave_writedata     : write data
//   slave_waitrequest   : high = request not accepted this cycle
//   slave_readdata      : read data, holds last value when not valid
//   slave_readdatavalid : one-cycle pulse per returned read
// ----------------------------------------------------------------------------
module vec_mem_responder #(
    parameter int DEPTH_LOG2   = 6,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PENDING  = 2,
    parameter int STALL_EVERY  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    output logic        slave_waitrequest,
    output logic [31:0] slave_readdata,
    output logic        slave_readdatavalid
);

    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam int THR_W  = (STALL_EVERY > 0) ? $clog2(STALL_EVERY + 1) : 1;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } thr_state_t;

    // Pending-read counter update: simultaneous accept and return cancel out.
    function automatic logic [PEND_W-1:0] pend_next(
        input logic [PEND_W-1:0] cnt,
        input logic              inc,
        input logic              dec
    );
        logic [PEND_W-1:0] nxt;
        nxt = cnt;
        if (inc && !dec) begin
            nxt = cnt + PEND_W'(1);
        end else if (!inc && dec) begin
            nxt = cnt - PEND_W'(1);
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    thr_state_t        thr_state;
    logic [THR_W-1:0]  thr_cnt;
    logic [PEND_W-1:0] pend_cnt;

    // Storage starts out all-zero and is never touched by reset.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  acc;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  addr_unused;

    assign word_idx    = slave_address[DEPTH_LOG2+1:2];
    assign addr_unused = ^{slave_address[31:DEPTH_LOG2+2], slave_address[1:0]};

    // Waitrequest is decoded only from registered state (and reset), so a
    // master can never form a combinational loop through it.
    assign slave_waitrequest = rst
                             | (thr_state == STALL)
                             | (pend_cnt == PEND_W'(MAX_PENDING));

    assign acc    = (slave_read | slave_write) & ~slave_waitrequest;
    assign wr_acc = acc & slave_write;
    // A read presented together with a write is dropped.
    assign rd_acc = acc & slave_read & ~slave_write;

    // ------------------------------------------------------------------
    // Memory write: lands at the end of the accepting cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[word_idx] <= slave_writedata;
        end
    end

    // ------------------------------------------------------------------
    // Read latency pipeline: stage 0 captures the word at the end of the
    // accepting cycle, the last stage drives readdatavalid
    // ------------------------------------------------------------------
    logic              vld_p  [READ_LATENCY];
    logic [DATA_W-1:0] data_p [READ_LATENCY];
    logic [DATA_W-1:0] rdata_hold;
    logic              vld_out;
    logic [DATA_W-1:0] data_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_p[i] <= 1'b0;
            end
        end else begin
            vld_p[0] <= rd_acc;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Data stages carry no reset; they only move when a valid rides along.
    always_ff @(posedge clk) begin
        if (rd_acc) begin
            data_p[0] <= mem[word_idx];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            if (vld_p[i-1]) begin
                data_p[i] <= data_p[i-1];
            end
        end
    end

    assign vld_out  = vld_p[READ_LATENCY-1];
    assign data_out = data_p[READ_LATENCY-1];

    // ------------------------------------------------------------------
    // Output stage: readdata follows the returning word in its valid
    // cycle and otherwise holds the last returned value
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_hold <= '0;
        end else if (vld_out) begin
            rdata_hold <= data_out;
        end
    end

    assign slave_readdatavalid = vld_out & ~rst;
    assign slave_readdata      = rst     ? '0       :
                                 vld_out ? data_out : rdata_hold;

    // ------------------------------------------------------------------
    // Outstanding-read accounting
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_cnt <= '0;
        end else begin
            pend_cnt <= pend_next(pend_cnt, rd_acc, slave_readdatavalid);
        end
    end

    // ------------------------------------------------------------------
    // Throttle FSM: RUN counts accepted transfers; reaching STALL_EVERY
    // enters STALL for exactly one cycle, during which nothing is accepted
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            thr_state <= RUN;
            thr_cnt   <= '0;
        end else begin
            case (thr_state)
                RUN: begin
                    if (acc && (STALL_EVERY != 0)) begin
                        if (thr_cnt == THR_W'(STALL_EVERY - 1)) begin
                            thr_state <= STALL;
                            thr_cnt   <= '0;
                        end else begin
                            thr_cnt <= thr_cnt + THR_W'(1);
                        end
                    end
                end
                STALL: begin
                    thr_state <= RUN;
                end
                default: begin
                    thr_state <= RUN;
                    thr_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_vec_mem_responder
//
// Self-checking bench for vec_mem_responder. A default-parameter instance is
// driven by a table of directed vectors, hand-written reset and throttle
// sequences, and a randomized run checked against a transaction-level model.
// A second instance with the throttle disabled covers pending-read limiting.
// ----------------------------------------------------------------------------
module tb_vec_mem_responder;

    localparam int DL = 6;
    localparam int L  = 2;
    localparam int MP = 2;
    localparam int SE = 3;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] addr, wd;
    logic        rd, wr;
    logic        w_wait, w_vld;
    logic [31:0] w_rdata;

    logic [31:0] addr0, wd0;
    logic        rd0, wr0;
    logic        w_wait0, w_vld0;
    logic [31:0] w_rdata0;

    always #5 clk = ~clk;

    vec_mem_responder #(
        .DEPTH_LOG2  (DL),
        .READ_LATENCY(L),
        .MAX_PENDING (MP),
        .STALL_EVERY (SE)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .slave_address      (addr),
        .slave_read         (rd),
        .slave_write        (wr),
        .slave_writedata    (wd),
        .slave_waitrequest  (w_wait),
        .slave_readdata     (w_rdata),
        .slave_readdatavalid(w_vld)
    );

    vec_mem_responder #(
        .DEPTH_LOG2  (DL),
        .READ_LATENCY(2),
        .MAX_PENDING (2),
        .STALL_EVERY (0)
    ) dut0 (
        .clk                (clk),
        .rst                (rst),
        .slave_address      (addr0),
        .slave_read         (rd0),
        .slave_write        (wr0),
        .slave_writedata    (wd0),
        .slave_waitrequest  (w_wait0),
        .slave_readdata     (w_rdata0),
        .slave_readdatavalid(w_vld0)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level reference model of the default instance
    // ------------------------------------------------------------------
    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } ret_t;

    logic [31:0] m_mem [64];
    ret_t        m_q[$];
    int          m_cnt;
    bit          m_stall;
    logic [31:0] m_last;
    int unsigned cyc;
    bit          chk_model;

    logic        s_wait, s_vld, s_wait0, s_vld0;
    logic [31:0] s_rdata, s_rdata0;

    // One clock cycle: sample both DUTs mid-cycle, optionally compare the
    // default instance with the model, advance the model, then step past
    // the rising edge so new inputs can be applied.
    task automatic tick();
        logic        e_wait, e_vld;
        logic [31:0] e_rdata;
        ret_t        r;
        int          idx;
        @(negedge clk);
        s_wait   = w_wait;
        s_vld    = w_vld;
        s_rdata  = w_rdata;
        s_wait0  = w_wait0;
        s_vld0   = w_vld0;
        s_rdata0 = w_rdata0;
        if (rst) begin
            e_wait  = 1'b1;
            e_vld   = 1'b0;
            e_rdata = 32'h0;
        end else begin
            e_wait  = m_stall || (m_q.size() == MP);
            e_vld   = (m_q.size() > 0) && (m_q[0].due == cyc);
            e_rdata = e_vld ? m_q[0].data : m_last;
        end
        if (chk_model) begin
            check("model_wait", {31'b0, s_wait}, {31'b0, e_wait});
            check("model_vld", {31'b0, s_vld}, {31'b0, e_vld});
            check("model_rdata", s_rdata, e_rdata);
        end
        if (rst) begin
            m_q.delete();
            m_cnt   = 0;
            m_stall = 1'b0;
            m_last  = 32'h0;
        end else begin
            if (e_vld) begin
                m_last = m_q[0].data;
                void'(m_q.pop_front());
            end
            m_stall = 1'b0;
            if ((rd || wr) && !e_wait) begin
                idx = int'(addr[DL+1:2]);
                if (wr) begin
                    m_mem[idx] = wd;
                end else begin
                    r.due  = cyc + L;
                    r.data = m_mem[idx];
                    m_q.push_back(r);
                end
                m_cnt++;
                if (SE != 0 && m_cnt == SE) begin
                    m_stall = 1'b1;
                    m_cnt   = 0;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        e_wait;
        logic        e_vld;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic ew, input logic ev, input logic [31:0] er);
        vec_t v;
        v.rd = r; v.wr = w; v.addr = a; v.wd = d;
        v.e_wait = ew; v.e_vld = ev; v.e_rdata = er;
        tbl.push_back(v);
    endtask

    logic [31:0] eq0[$];
    int          nk;
    int          ret_n;
    logic        exp_w;

    initial begin
        rst = 1'b1;
        rd = 1'b0; wr = 1'b0; addr = '0; wd = '0;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wd0 = '0;
        cyc = 0; m_cnt = 0; m_stall = 1'b0; m_last = '0; chk_model = 1'b0;
        for (int i = 0; i < 64; i++) m_mem[i] = '0;

        // Two writes, a third to trigger the stall, back-to-back reads
        add_vec(0, 1, 32'h0,   32'h000A0000, 0, 0, 32'h0);
        add_vec(0, 1, 32'h4,   32'hFFF60000, 0, 0, 32'h0);
        add_vec(0, 1, 32'h8,   32'h12345678, 0, 0, 32'h0);
        add_vec(1, 0, 32'h0,   32'h0,        1, 0, 32'h0);
        add_vec(1, 0, 32'h0,   32'h0,        0, 0, 32'h0);
        add_vec(1, 0, 32'h4,   32'h0,        0, 0, 32'h0);
        add_vec(0, 0, 32'h0,   32'h0,        1, 1, 32'h000A0000);
        add_vec(0, 0, 32'h0,   32'h0,        0, 1, 32'hFFF60000);
        add_vec(0, 0, 32'h0,   32'h0,        0, 0, 32'hFFF60000);
        // Address wrap-around
        add_vec(0, 1, 32'h100, 32'h000E0000, 0, 0, 32'hFFF60000);
        add_vec(1, 0, 32'h0,   32'h0,        1, 0, 32'hFFF60000);
        add_vec(1, 0, 32'h0,   32'h0,        0, 0, 32'hFFF60000);
        add_vec(0, 0, 32'h0,   32'h0,        0, 0, 32'hFFF60000);
        add_vec(0, 0, 32'h0,   32'h0,        0, 1, 32'h000E0000);
        // Read+write together: write only, no return
        add_vec(1, 1, 32'h8,   32'h00030000, 0, 0, 32'h000E0000);
        add_vec(0, 0, 32'h0,   32'h0,        0, 0, 32'h000E0000);
        add_vec(1, 0, 32'h8,   32'h0,        0, 0, 32'h000E0000);
        add_vec(0, 0, 32'h0,   32'h0,        1, 0, 32'h000E0000);
        add_vec(0, 0, 32'h0,   32'h0,        0, 1, 32'h00030000);
        add_vec(0, 0, 32'h0,   32'h0,        0, 0, 32'h00030000);

        // Reset state
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_wait", {31'b0, s_wait}, 32'h1);
            check("reset_vld", {31'b0, s_vld}, 32'h0);
            check("reset_rdata", s_rdata, 32'h0);
        end
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            rd = tbl[i].rd; wr = tbl[i].wr; addr = tbl[i].addr; wd = tbl[i].wd;
            tick();
            check($sformatf("vec%0d_wait", i), {31'b0, s_wait}, {31'b0, tbl[i].e_wait});
            check($sformatf("vec%0d_vld", i), {31'b0, s_vld}, {31'b0, tbl[i].e_vld});
            check($sformatf("vec%0d_rdata", i), s_rdata, tbl[i].e_rdata);
        end
        rd = 1'b0; wr = 1'b0;

        // Continuous writes: one stall cycle after every third acceptance
        rst = 1'b1; tick(); rst = 1'b0;
        wr = 1'b1;
        for (int i = 0; i < 12; i++) begin
            addr = 32'h40 + 32'(i * 4);
            wd   = 32'h5A000000 + 32'(i);
            tick();
            exp_w = (i % 4 == 3);
            check($sformatf("thr_wait%0d", i), {31'b0, s_wait}, {31'b0, exp_w});
        end
        wr = 1'b0;

        // Reset while a read is in flight
        rst = 1'b1; tick(); rst = 1'b0;
        rd = 1'b1; addr = 32'h40;
        tick();
        check("inflight_accept_wait", {31'b0, s_wait}, 32'h0);
        rd = 1'b0; rst = 1'b1;
        tick();
        check("inflight_rst_wait", {31'b0, s_wait}, 32'h1);
        check("inflight_rst_vld", {31'b0, s_vld}, 32'h0);
        check("inflight_rst_rdata", s_rdata, 32'h0);
        rst = 1'b0;
        tick();
        check("inflight_after_vld", {31'b0, s_vld}, 32'h0);
        check("inflight_after_wait", {31'b0, s_wait}, 32'h0);
        tick();
        check("inflight_after2_vld", {31'b0, s_vld}, 32'h0);

        // Pending limit with throttle disabled (second instance)
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wr0 = 1'b1; addr0 = 32'(k * 4); wd0 = 32'h00C00000 + 32'(k);
            tick();
            check("pend_wr_wait", {31'b0, s_wait0}, 32'h0);
        end
        wr0 = 1'b0; rd0 = 1'b1;
        nk = 0; ret_n = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 12) rd0 = 1'b0;
            addr0 = 32'((nk % 4) * 4);
            tick();
            if (i < 12) begin
                exp_w = (i % 3 == 2);
                check($sformatf("pend_wait%0d", i), {31'b0, s_wait0}, {31'b0, exp_w});
            end
            if (s_vld0) begin
                ret_n++;
                if (eq0.size() == 0) begin
                    n_errors++;
                    $display("FAIL pend_extra_return: got 0x%08h, expected no return", s_rdata0);
                end else begin
                    check("pend_data", s_rdata0, eq0.pop_front());
                end
            end
            if (rd0 && !s_wait0) begin
                eq0.push_back(32'h00C00000 + 32'(nk % 4));
                nk++;
            end
        end
        check("pend_accepts", 32'(nk), 32'd8);
        check("pend_returns", 32'(ret_n), 32'(nk));

        // Randomized traffic against the model
        chk_model = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 59) == 0);
            rd   = $urandom_range(0, 1) == 1;
            wr   = $urandom_range(0, 3) == 0;
            addr = $urandom() & 32'hFFFFFF3F;
            wd   = $urandom();
            tick();
        end
        rst = 1'b0; rd = 1'b0; wr = 1'b0;
        for (int i = 0; i < L + 3; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
